idelay_tap_calib: RTL and testbench

//  Calibration sequencer for one IDELAYE2 lane in VAR_LOAD mode. After IDELAYCTRL reports ready,
//  it sweeps every tap, loading each tap value and qualifying it with a downstream pattern checker.
//  It finds the widest contiguous passing window and loads the window centre as the operating tap.
//  It drives the delay wrapper's ld/cntvaluein pins; ce, inc, ldpipeen and reg_rst are tied 0 outside this block.

---
 rtl/idelay_tap_calib.sv | 245 ++++++++++++++++++++++++
 tb/tb_idelay_tap_calib.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/idelay_tap_calib.sv
// Tap-sweep calibration sequencer for one IDELAYE2 lane in VAR_LOAD mode.
// Loads every tap, qualifies it with the pattern checker and applies the centre of the widest passing window.
module idelay_tap_calib #(
  parameter int NUM_TAPS   = 32,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 64,
  parameter int MIN_WIN    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dly_rdy,
  input  logic [4:0] cntvalueout,
  input  logic       sample_vld,
  input  logic       sample_ok,
  output logic       ld,
  output logic [4:0] cntvaluein,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       rb_err,
  output logic [4:0] best_tap,
  output logic [5:0] win_len
);

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, LOAD, SETTLE, SAMPLE, EVAL, APPLY, VERIFY, DONE
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYC - 1);
  localparam logic [4:0]  TAP_LAST    = 5'(NUM_TAPS - 1);
  localparam logic [5:0]  MIN_LEN     = 6'(MIN_WIN);

  state_t      state_reg, state_next;
  logic [4:0]  tap_reg, tap_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        pass_reg, pass_next;
  logic [5:0]  cur_len_reg, cur_len_next;
  logic [5:0]  cur_start_reg, cur_start_next;
  logic [5:0]  best_len_reg, best_len_next;
  logic [5:0]  best_start_reg, best_start_next;
  logic        ld_reg, ld_next;
  logic [4:0]  cntvaluein_reg, cntvaluein_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        fail_reg, fail_next;
  logic        rb_err_reg, rb_err_next;
  logic [4:0]  best_tap_reg, best_tap_next;
  logic [5:0]  win_len_reg, win_len_next;
  logic [5:0]  new_len;
  logic [5:0]  centre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tap_reg        <= '0;
      cnt_reg        <= '0;
      pass_reg       <= 1'b0;
      cur_len_reg    <= '0;
      cur_start_reg  <= '0;
      best_len_reg   <= '0;
      best_start_reg <= '0;
      ld_reg         <= 1'b0;
      cntvaluein_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      fail_reg       <= 1'b0;
      rb_err_reg     <= 1'b0;
      best_tap_reg   <= '0;
      win_len_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      tap_reg        <= tap_next;
      cnt_reg        <= cnt_next;
      pass_reg       <= pass_next;
      cur_len_reg    <= cur_len_next;
      cur_start_reg  <= cur_start_next;
      best_len_reg   <= best_len_next;
      best_start_reg <= best_start_next;
      ld_reg         <= ld_next;
      cntvaluein_reg <= cntvaluein_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      fail_reg       <= fail_next;
      rb_err_reg     <= rb_err_next;
      best_tap_reg   <= best_tap_next;
      win_len_reg    <= win_len_next;
    end
  end

  // ld/cntvaluein are registered, so each load is set up on the transition into LOAD or APPLY.
  always_comb begin
    state_next      = state_reg;
    tap_next        = tap_reg;
    cnt_next        = cnt_reg;
    pass_next       = pass_reg;
    cur_len_next    = cur_len_reg;
    cur_start_next  = cur_start_reg;
    best_len_next   = best_len_reg;
    best_start_next = best_start_reg;
    ld_next         = 1'b0;
    cntvaluein_next = cntvaluein_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    fail_next       = fail_reg;
    rb_err_next     = rb_err_reg;
    best_tap_next   = best_tap_reg;
    win_len_next    = win_len_reg;
    new_len         = cur_len_reg + 6'd1;
    centre          = '0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          fail_next       = 1'b0;
          rb_err_next     = 1'b0;
          cur_len_next    = '0;
          cur_start_next  = '0;
          best_len_next   = '0;
          best_start_next = '0;
          tap_next        = '0;
          busy_next       = 1'b1;
          state_next      = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (dly_rdy) begin
          ld_next         = 1'b1;
          cntvaluein_next = tap_reg;
          state_next      = LOAD;
        end
      end
      LOAD: begin
        cnt_next   = '0;
        state_next = SETTLE;
      end
      SETTLE: begin
        if (cnt_reg == SETTLE_LAST) begin
          if (cntvalueout != tap_reg) begin
            rb_err_next = 1'b1;
            fail_next   = 1'b1;
            busy_next   = 1'b0;
            done_next   = 1'b1;
            state_next  = DONE;
          end else begin
            cnt_next   = '0;
            pass_next  = 1'b1;
            state_next = SAMPLE;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      SAMPLE: begin
        if (sample_vld) begin
          if (!sample_ok) pass_next = 1'b0;
          if (cnt_reg == SAMPLE_LAST) state_next = EVAL;
          else cnt_next = cnt_reg + 16'd1;
        end
      end
      EVAL: begin
        if (pass_reg) begin
          cur_len_next = new_len;
          if (new_len > best_len_reg) begin
            best_len_next   = new_len;
            best_start_next = cur_start_reg;
          end
        end else begin
          cur_len_next   = '0;
          cur_start_next = {1'b0, tap_reg} + 6'd1;
        end
        if (tap_reg == TAP_LAST) begin
          centre     = best_start_next + ((best_len_next - 6'd1) >> 1);
          state_next = APPLY;
          if (best_len_next >= MIN_LEN) begin
            ld_next         = 1'b1;
            cntvaluein_next = 5'(centre);
          end
        end else begin
          tap_next        = tap_reg + 5'd1;
          ld_next         = 1'b1;
          cntvaluein_next = tap_reg + 5'd1;
          state_next      = LOAD;
        end
      end
      APPLY: begin
        win_len_next = best_len_reg;
        if (best_len_reg < MIN_LEN) begin
          fail_next  = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          best_tap_next = cntvaluein_reg;
          cnt_next      = '0;
          state_next    = VERIFY;
        end
      end
      VERIFY: begin
        if (cnt_reg == SETTLE_LAST) begin
          if (cntvalueout != best_tap_reg) begin
            rb_err_next = 1'b1;
            fail_next   = 1'b1;
          end
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Losing the delay controller invalidates every tap measured so far: restart the sweep silently.
    if (!dly_rdy && state_reg != IDLE && state_reg != DONE) begin
      state_next      = WAIT_RDY;
      tap_next        = '0;
      cur_len_next    = '0;
      cur_start_next  = '0;
      best_len_next   = '0;
      best_start_next = '0;
      ld_next         = 1'b0;
      cntvaluein_next = cntvaluein_reg;
      busy_next       = 1'b1;
      done_next       = 1'b0;
      fail_next       = fail_reg;
      rb_err_next     = rb_err_reg;
      best_tap_next   = best_tap_reg;
      win_len_next    = win_len_reg;
    end
  end

  assign ld         = ld_reg;
  assign cntvaluein = cntvaluein_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign fail       = fail_reg;
  assign rb_err     = rb_err_reg;
  assign best_tap   = best_tap_reg;
  assign win_len    = win_len_reg;

endmodule

// File: tb/tb_idelay_tap_calib.sv
// Directed bench for idelay_tap_calib: models the IDELAYE2 tap register and a per-tap pass/fail checker.
module tb_idelay_tap_calib;

  logic       clk = 1'b0;
  logic       rst_n, start, dly_rdy, sample_vld, sample_ok;
  logic [4:0] cntvalueout, cntvaluein, best_tap;
  logic       ld, busy, done, fail, rb_err;
  logic [5:0] win_len;

  logic [31:0] pass_mask = '1;
  logic        force_zero = 1'b0;
  logic        gap_mode = 1'b0;
  logic [4:0]  dly_val = '0;
  int          ld_count = 0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  idelay_tap_calib dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dly_rdy(dly_rdy),
    .cntvalueout(cntvalueout), .sample_vld(sample_vld), .sample_ok(sample_ok),
    .ld(ld), .cntvaluein(cntvaluein), .busy(busy), .done(done), .fail(fail),
    .rb_err(rb_err), .best_tap(best_tap), .win_len(win_len)
  );

  // Delay line model: the tap value is captured on LD at the clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) begin
      dly_val  <= cntvaluein;
      ld_count <= ld_count + 1;
    end
  end

  always_comb begin
    sample_vld  = gap_mode ? ((cyc % 3) != 0) : 1'b1;
    sample_ok   = sample_vld & pass_mask[dly_val];
    cntvalueout = (force_zero && dly_val == 5'd5) ? 5'd0 : dly_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ld"}, ld, 0);
    chk({tag, " cntvaluein"}, cntvaluein, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " fail"}, fail, 0);
    chk({tag, " rb_err"}, rb_err, 0);
    chk({tag, " best_tap"}, best_tap, 0);
    chk({tag, " win_len"}, win_len, 0);
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_at_done"}, busy, 0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_ok(input string tag, input logic [31:0] mask, input int exp_tap, input int exp_len);
    int base;
    pass_mask = mask;
    base = ld_count;
    pulse_start();
    wait_done(tag);
    chk({tag, " best_tap"}, best_tap, exp_tap);
    chk({tag, " win_len"}, win_len, exp_len);
    chk({tag, " fail"}, fail, 0);
    chk({tag, " rb_err"}, rb_err, 0);
    chk({tag, " ld_pulses"}, ld_count - base, 33);
    @(negedge clk);
    chk({tag, " done_width"}, done, 0);
    chk({tag, " applied_tap"}, cntvalueout, exp_tap);
  endtask

  initial begin
    int base;
    int n;
    logic saw_done, saw_idle;
    rst_n = 1'b0; start = 1'b0; dly_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: every tap passes
    run_ok("all_pass", 32'hFFFF_FFFF, 15, 32);
    $display("txn all_pass best_tap=%0d win_len=%0d fail=%0d", best_tap, win_len, fail);

    // 2: window 10..20
    run_ok("win10_20", 32'h001F_FC00, 15, 11);
    $display("txn win10_20 best_tap=%0d win_len=%0d fail=%0d", best_tap, win_len, fail);

    // 3: two equal windows, earliest wins; a second start mid-run is ignored
    pass_mask = 32'h00F0_0078;
    base = ld_count;
    pulse_start();
    repeat (50) @(negedge clk);
    pulse_start();
    wait_done("tie");
    chk("tie best_tap", best_tap, 4);
    chk("tie win_len", win_len, 4);
    chk("tie fail", fail, 0);
    chk("tie ld_pulses", ld_count - base, 33);
    $display("txn tie best_tap=%0d win_len=%0d fail=%0d", best_tap, win_len, fail);

    // 4: window too short
    do_reset();
    pass_mask = 32'h0000_0380;
    base = ld_count;
    pulse_start();
    wait_done("short");
    chk("short fail", fail, 1);
    chk("short rb_err", rb_err, 0);
    chk("short win_len", win_len, 3);
    chk("short best_tap", best_tap, 0);
    chk("short ld_pulses", ld_count - base, 32);
    chk("short last_tap", cntvaluein, 31);
    $display("txn short fail=%0d win_len=%0d best_tap=%0d", fail, win_len, best_tap);

    // 5: readback error at tap 5
    pass_mask = 32'hFFFF_FFFF;
    force_zero = 1'b1;
    base = ld_count;
    pulse_start();
    wait_done("rb");
    chk("rb rb_err", rb_err, 1);
    chk("rb fail", fail, 1);
    chk("rb ld_pulses", ld_count - base, 6);
    repeat (30) @(negedge clk);
    chk("rb no_more_ld", ld_count - base, 6);
    chk("rb idle_busy", busy, 0);
    force_zero = 1'b0;
    $display("txn rb rb_err=%0d fail=%0d loads=%0d", rb_err, fail, ld_count - base);

    // 6a: dly_rdy drop during SAMPLE of tap 12 with gapped sample_vld
    pass_mask = 32'h001F_FC00;
    gap_mode = 1'b1;
    base = ld_count;
    pulse_start();
    n = 0;
    while ((ld_count - base) < 13 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drop reach_tap12", ld_count - base, 13);
    repeat (20) @(negedge clk);
    dly_rdy = 1'b0;
    saw_done = 1'b0;
    saw_idle = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (!busy) saw_idle = 1'b1;
    end
    chk("drop no_done", saw_done, 0);
    chk("drop busy_held", saw_idle, 0);
    dly_rdy = 1'b1;
    n = 0;
    while (!ld && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drop restart_ld", ld, 1);
    chk("drop restart_tap", cntvaluein, 0);
    wait_done("drop");
    chk("drop best_tap", best_tap, 15);
    chk("drop win_len", win_len, 11);
    chk("drop fail", fail, 0);
    chk("drop ld_pulses", ld_count - base, 46);
    gap_mode = 1'b0;
    $display("txn drop best_tap=%0d win_len=%0d loads=%0d", best_tap, win_len, ld_count - base);

    // 6b: asynchronous reset mid-SETTLE
    pulse_start();
    n = 0;
    while (!ld && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    base = ld_count;
    repeat (20) @(negedge clk);
    chk("midrst idle_busy", busy, 0);
    chk("midrst no_ld", ld_count - base, 0);
    $display("txn midrst busy=%0d best_tap=%0d", busy, best_tap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
